// File: rtl/bram_rd_pkg.sv
// Shared definitions for the block-RAM stream reader: default geometry and FSM encoding.
package bram_rd_pkg;
  localparam int BRAM_ADDR_W = 12;
  localparam int BRAM_WIDTH  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry in-order output buffer; slot 0 is always the head presented downstream.
module bram_rd_skid #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] data
);
  logic [W-1:0] slot0_reg, slot1_reg;
  logic [1:0]   count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_reg <= '0;
      slot1_reg <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) slot0_reg <= push_data;
          else                   slot1_reg <= push_data;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          slot0_reg <= slot1_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever survives the pop.
          if (count_reg == 2'd1) begin
            slot0_reg <= push_data;
          end else begin
            slot0_reg <= slot1_reg;
            slot1_reg <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_reg;
  assign data  = slot0_reg;
endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a registered-output block RAM and streams
// them out on a valid/ready interface with a last-beat marker.
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int WIDTH  = BRAM_WIDTH,
  parameter int ADDR_W = BRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last
);
  rd_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   issued_reg;
  logic              rd_valid_reg, rd_last_reg, done_reg;
  logic [1:0]        count;
  logic [WIDTH:0]    head;
  logic              pop, last_issue, accept, accept_zero;
  logic [2:0]        pending;

  assign m_valid     = (count != 2'd0);
  assign pop         = m_valid && m_ready;
  assign m_data      = head[WIDTH-1:0];
  assign m_last      = m_valid && head[WIDTH];
  assign done        = done_reg;
  assign last_issue  = (issued_reg == len_reg - (ADDR_W+1)'(1));
  assign accept      = (state_reg == ST_IDLE) && start && (length != '0);
  assign accept_zero = (state_reg == ST_IDLE) && start && (length == '0);
  // A word popped this cycle already frees its slot, which keeps one word per cycle flowing.
  assign pending     = 3'(count) + 3'(rd_valid_reg) - 3'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_READ;
      ST_READ:  if (mem_en && last_issue) state_next = ST_DRAIN;
      ST_DRAIN: if (pop && head[WIDTH]) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != ST_IDLE);
    mem_en   = 1'b0;
    mem_addr = '0;
    if (state_reg == ST_READ) begin
      mem_en   = (pending < 3'd2);
      mem_addr = base_reg + issued_reg[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg     <= '0;
      len_reg      <= '0;
      issued_reg   <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if (accept) begin
        base_reg   <= base_addr;
        len_reg    <= length;
        issued_reg <= '0;
      end else if (mem_en) begin
        issued_reg <= issued_reg + (ADDR_W+1)'(1);
      end
      rd_valid_reg <= mem_en;
      rd_last_reg  <= mem_en && last_issue;
      done_reg     <= accept_zero || ((state_reg == ST_DRAIN) && pop && head[WIDTH]);
    end
  end

  bram_rd_skid #(.W(WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_valid_reg),
    .push_data ({rd_last_reg, mem_dout}),
    .pop       (pop),
    .count     (count),
    .data      (head)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: table of bursts plus reset-abort sequence.
module tb_bram_stream_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic        busy, done, mem_en, m_valid, m_last;
  logic [11:0] mem_addr;
  logic [23:0] mem_dout = '0;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // RAM model with registered read: RAM[i] = i
  always @(posedge clk) if (mem_en) mem_dout <= {12'h000, mem_addr};

  bram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  typedef struct {
    logic [11:0] base;
    logic [12:0] len;
    logic [3:0]  rdy_pat;
    logic        mid_start;
    logic [23:0] exp_first;
    logic [23:0] exp_last;
    int          exp_beats;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int issued = 0, popped = 0, last_hs = -10, first_valid = -1, pending;
    bit done_seen = 0, stalled = 0;
    logic [23:0] prev_data = '0;
    logic prev_last = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; length = v.len;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.mid_start && (cyc == 3)) begin
        start = 1'b1; base_addr = 12'h7FF; length = 13'd9;
      end
      m_ready = v.rdy_pat[cyc % 4];
      #1;
      if (cyc == 0) check($sformatf("v%0d_busy_start", id), 32'(busy), 32'(v.len != 0));
      if (v.len == 0 && (m_valid || mem_en))
        check($sformatf("v%0d_len0_activity", id), 32'({m_valid, mem_en}), 32'd0);
      if (m_valid && first_valid < 0) begin
        first_valid = cyc;
        check($sformatf("v%0d_first_valid_cyc", id), 32'(cyc), 32'd2);
      end
      if (stalled) begin
        check($sformatf("v%0d_stall_data", id), 32'(m_data), 32'(prev_data));
        check($sformatf("v%0d_stall_valid", id), 32'(m_valid), 32'd1);
        check($sformatf("v%0d_stall_last", id), 32'(m_last), 32'(prev_last));
      end
      if (mem_en) begin
        pending = issued - popped - int'(m_valid && m_ready);
        if (pending >= 2) check($sformatf("v%0d_occupancy", id), 32'(pending), 32'd1);
        check($sformatf("v%0d_addr%0d", id, issued), 32'(mem_addr), 32'(12'(v.base + 12'(issued))));
        issued++;
      end
      if (m_valid && m_ready) begin
        check($sformatf("v%0d_beat%0d", id, popped), 32'(m_data), 32'(12'(v.base + 12'(popped))));
        check($sformatf("v%0d_last%0d", id, popped), 32'(m_last), 32'(popped == int'(v.len) - 1));
        if (popped == 0) check($sformatf("v%0d_first", id), 32'(m_data), 32'(v.exp_first));
        if (popped == int'(v.len) - 1) check($sformatf("v%0d_final", id), 32'(m_data), 32'(v.exp_last));
        popped++;
        last_hs = cyc;
      end
      if (done) begin
        done_seen = 1;
        check($sformatf("v%0d_done_cyc", id), 32'(cyc), (v.len == 0) ? 32'd0 : 32'(last_hs + 1));
        check($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd0);
      end
      stalled = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
    check($sformatf("v%0d_done_seen", id), 32'(done_seen), 32'd1);
    check($sformatf("v%0d_beats", id), 32'(popped), 32'(v.exp_beats));
    check($sformatf("v%0d_issued", id), 32'(issued), 32'(v.exp_beats));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check($sformatf("v%0d_quiet%0d", id, k), 32'({done, m_valid, mem_en, busy}), 32'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int hs;
    vec_t rv;
    vecs[0] = '{12'h010, 13'd4, 4'b1111, 1'b0, 24'h000010, 24'h000013, 4};
    vecs[1] = '{12'hFFE, 13'd4, 4'b1111, 1'b0, 24'h000FFE, 24'h000001, 4};
    vecs[2] = '{12'h020, 13'd8, 4'b1001, 1'b0, 24'h000020, 24'h000027, 8};
    vecs[3] = '{12'h100, 13'd0, 4'b1111, 1'b0, 24'h000000, 24'h000000, 0};
    vecs[4] = '{12'h300, 13'd5, 4'b1101, 1'b1, 24'h000300, 24'h000304, 5};
    vecs[5] = '{12'h000, 13'd1, 4'b1111, 1'b0, 24'h000000, 24'h000000, 1};
    vecs[6] = '{12'hFFF, 13'd3, 4'b0110, 1'b0, 24'h000FFF, 24'h000001, 3};

    repeat (3) @(negedge clk);
    #1 check_idle_outputs("por");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort a 16-word burst after its third beat with an asynchronous reset
    @(negedge clk);
    start = 1'b1; base_addr = 12'h000; length = 13'd16;
    hs = 0;
    for (int cyc = 0; cyc < 60 && hs < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0; m_ready = 1'b1;
      #1;
      if (m_valid && m_ready) hs++;
    end
    check("abort_beats_before_reset", 32'(hs), 32'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_idle_outputs("abort_rst");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check($sformatf("abort_no_done%0d", k), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("abort_after_release_done", 32'(done), 32'd0);
    rv = '{12'h000, 13'd2, 4'b1111, 1'b0, 24'h000000, 24'h000001, 2};
    run_vec(7, rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
